// File: rtl/ps2_xt_pkg.sv
// ps2_xt_pkg: shared types and constants for the PS/2 set-2 to XT set-1 translator.
//   state_t   : translator FSM states
//   PS2_*     : significant set-2 bytes seen from the keyboard
//   XT_*      : set-1 constants used when building the emitted byte
//   with_brk  : merges a 7-bit set-1 make code with the pending break flag
package ps2_xt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOK  = 2'd1,
    CLASS = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_EXT0   = 8'hE0;
  localparam logic [7:0] PS2_EXT1   = 8'hE1;
  localparam logic [7:0] PS2_F7     = 8'h83;
  localparam logic [7:0] XT_F7      = 8'h41;
  localparam int         XT_BRK_BIT = 7;

  // Set 1 signals a key release by setting bit 7 of the make code.
  function automatic logic [7:0] with_brk(input logic [6:0] code, input logic brk);
    logic [7:0] v;
    v = {1'b0, code};
    v[XT_BRK_BIT] = brk;
    return v;
  endfunction

endpackage

// File: rtl/ps2_set2_to_set1_rom.sv
// ps2_set2_to_set1_rom: registered 128x7 lookup from a set-2 scan code
// (bit 7 already known to be 0) to the matching set-1 make code.
// Codes without a set-1 equivalent read back as 7'h00.
//   busclk : system clock
//   addr   : set-2 code bits [6:0]
//   data   : set-1 make code, valid the cycle after addr is presented
module ps2_set2_to_set1_rom (
  input  logic       busclk,
  input  logic [6:0] addr,
  output logic [6:0] data
);

  function automatic logic [6:0] lut(input logic [6:0] a);
    logic [6:0] v;
    case (a)
      7'h01: v = 7'h43; 7'h03: v = 7'h3F; 7'h04: v = 7'h3D; 7'h05: v = 7'h3B;
      7'h06: v = 7'h3C; 7'h07: v = 7'h58; 7'h09: v = 7'h44; 7'h0A: v = 7'h42;
      7'h0B: v = 7'h40; 7'h0C: v = 7'h3E; 7'h0D: v = 7'h0F; 7'h0E: v = 7'h29;
      7'h11: v = 7'h38; 7'h12: v = 7'h2A; 7'h14: v = 7'h1D; 7'h15: v = 7'h10;
      7'h16: v = 7'h02; 7'h1A: v = 7'h2C; 7'h1B: v = 7'h1F; 7'h1C: v = 7'h1E;
      7'h1D: v = 7'h11; 7'h1E: v = 7'h03; 7'h21: v = 7'h2E; 7'h22: v = 7'h2D;
      7'h23: v = 7'h20; 7'h24: v = 7'h12; 7'h25: v = 7'h05; 7'h26: v = 7'h04;
      7'h29: v = 7'h39; 7'h2A: v = 7'h2F; 7'h2B: v = 7'h21; 7'h2C: v = 7'h14;
      7'h2D: v = 7'h13; 7'h2E: v = 7'h06; 7'h31: v = 7'h31; 7'h32: v = 7'h30;
      7'h33: v = 7'h23; 7'h34: v = 7'h22; 7'h35: v = 7'h15; 7'h36: v = 7'h07;
      7'h3A: v = 7'h32; 7'h3B: v = 7'h24; 7'h3C: v = 7'h16; 7'h3D: v = 7'h08;
      7'h3E: v = 7'h09; 7'h41: v = 7'h33; 7'h42: v = 7'h25; 7'h43: v = 7'h17;
      7'h44: v = 7'h18; 7'h45: v = 7'h0B; 7'h46: v = 7'h0A; 7'h49: v = 7'h34;
      7'h4A: v = 7'h35; 7'h4B: v = 7'h26; 7'h4C: v = 7'h27; 7'h4D: v = 7'h19;
      7'h4E: v = 7'h0C; 7'h52: v = 7'h28; 7'h54: v = 7'h1A; 7'h55: v = 7'h0D;
      7'h58: v = 7'h3A; 7'h59: v = 7'h36; 7'h5A: v = 7'h1C; 7'h5B: v = 7'h1B;
      7'h5D: v = 7'h2B; 7'h61: v = 7'h56; 7'h66: v = 7'h0E; 7'h69: v = 7'h4F;
      7'h6B: v = 7'h4B; 7'h6C: v = 7'h47; 7'h70: v = 7'h52; 7'h71: v = 7'h53;
      7'h72: v = 7'h50; 7'h73: v = 7'h4C; 7'h74: v = 7'h4D; 7'h75: v = 7'h48;
      7'h76: v = 7'h01; 7'h77: v = 7'h45; 7'h78: v = 7'h57; 7'h79: v = 7'h4E;
      7'h7A: v = 7'h51; 7'h7B: v = 7'h4A; 7'h7C: v = 7'h37; 7'h7D: v = 7'h49;
      7'h7E: v = 7'h46;
      default: v = 7'h00;
    endcase
    return v;
  endfunction

  always_ff @(posedge busclk) begin
    data <= lut(addr);
  end

endmodule

// File: rtl/ps2_xt_translator.sv
// ps2_xt_translator: pulls bytes from the PS/2 receiver FIFO, converts scan
// code set 2 to XT set 1 and presents them on the 8088 keyboard port with IRQ1.
// Build option: PS2_XT_EXT_PREFIX_EN -- when defined, E0/E1 prefixes are passed
// to the host; when undefined they are swallowed (83-key XT behaviour).
//   busclk   : system clock
//   rstn     : asynchronous active-low reset (deassertion synchronised here)
//   rx_empty : upstream FIFO empty
//   fifo_top : upstream FIFO head byte
//   pop      : one-cycle pulse consuming fifo_top
//   kbd_data : translated byte for port 60h, held until the next emit
//   kbd_irq  : IRQ1 request (level or one-cycle pulse, see IRQ_LEVEL)
//   kbd_ack  : host read/clear strobe, releases the held byte
//   kbd_busy : high while a byte is held
module ps2_xt_translator
  import ps2_xt_pkg::*;
#(
  parameter int IRQ_LEVEL = 1
) (
  input  logic       busclk,
  input  logic       rstn,
  input  logic       rx_empty,
  input  logic [7:0] fifo_top,
  output logic       pop,
  output logic [7:0] kbd_data,
  output logic       kbd_irq,
  input  logic       kbd_ack,
  output logic       kbd_busy
);

  logic [1:0] rst_sync;
  logic       rst_sync_n;

  state_t     state, state_d;
  logic [7:0] raw, raw_d;
  logic       brk, brk_d;
  logic       ack_pend, ack_pend_d;
  logic       pop_d, irq_d, busy_d;
  logic [7:0] kbd_data_d;
  logic [6:0] rom_q;
  logic       emit;
  logic [7:0] emit_val;

  // Reset asserts immediately, releases two busclk edges after rstn rises.
  always_ff @(posedge busclk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_sync_n = rst_sync[1];

  ps2_set2_to_set1_rom u_rom (
    .busclk (busclk),
    .addr   (raw[6:0]),
    .data   (rom_q)
  );

  always_ff @(posedge busclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= IDLE;
      pop      <= 1'b0;
      kbd_data <= 8'h00;
      kbd_irq  <= 1'b0;
      kbd_busy <= 1'b0;
      brk      <= 1'b0;
      ack_pend <= 1'b0;
    end else begin
      state    <= state_d;
      pop      <= pop_d;
      kbd_data <= kbd_data_d;
      kbd_irq  <= irq_d;
      kbd_busy <= busy_d;
      brk      <= brk_d;
      ack_pend <= ack_pend_d;
    end
  end

  // Raw byte is pure data; it is always rewritten before it is used.
  always_ff @(posedge busclk) begin
    raw <= raw_d;
  end

  always_comb begin
    state_d    = state;
    pop_d      = 1'b0;
    raw_d      = raw;
    kbd_data_d = kbd_data;
    irq_d      = kbd_irq;
    busy_d     = kbd_busy;
    brk_d      = brk;
    ack_pend_d = 1'b0;
    emit       = 1'b0;
    emit_val   = 8'h00;

    case (state)
      IDLE: begin
        if (!rx_empty) begin
          raw_d   = fifo_top;
          pop_d   = 1'b1;
          state_d = LOOK;
        end
      end

      // ROM output for raw becomes valid at the end of this cycle.
      LOOK: state_d = CLASS;

      CLASS: begin
        state_d = IDLE;
        if (raw == PS2_BRK) begin
          brk_d = 1'b1;
        end else if (raw == PS2_EXT0 || raw == PS2_EXT1) begin
`ifdef PS2_XT_EXT_PREFIX_EN
          emit     = 1'b1;
          emit_val = raw;
`endif
        end else if (raw == PS2_F7) begin
          emit     = 1'b1;
          emit_val = with_brk(XT_F7[6:0], brk);
          brk_d    = 1'b0;
        end else if (!raw[7]) begin
          emit     = 1'b1;
          emit_val = with_brk(rom_q, brk);
          brk_d    = 1'b0;
        end else begin
          // Keyboard replies and overrun markers go through untouched.
          emit     = 1'b1;
          emit_val = raw;
          brk_d    = 1'b0;
        end

        if (emit) begin
          kbd_data_d = emit_val;
          busy_d     = 1'b1;
          irq_d      = 1'b1;
          state_d    = HOLD;
          // An ack racing the load is remembered and applied in HOLD.
          ack_pend_d = kbd_ack;
        end
      end

      HOLD: begin
        if (IRQ_LEVEL == 0) irq_d = 1'b0;
        if (kbd_ack || ack_pend) begin
          busy_d  = 1'b0;
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_xt_translator.sv
module tb_ps2_xt_translator;

  logic       busclk;
  logic       rstn;
  logic       rx_empty;
  logic [7:0] fifo_top;
  logic       pop;
  logic [7:0] kbd_data;
  logic       kbd_irq;
  logic       kbd_ack;
  logic       kbd_busy;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int irqs     = 0;
  bit irq_prev = 1'b0;

  logic [7:0] up_q[$];
  logic [7:0] exp_q[$];

  ps2_xt_translator #(.IRQ_LEVEL(1)) dut (
    .busclk   (busclk),
    .rstn     (rstn),
    .rx_empty (rx_empty),
    .fifo_top (fifo_top),
    .pop      (pop),
    .kbd_data (kbd_data),
    .kbd_irq  (kbd_irq),
    .kbd_ack  (kbd_ack),
    .kbd_busy (kbd_busy)
  );

  initial busclk = 1'b0;
  always #5 busclk = ~busclk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Upstream FIFO model: the head advances just after the edge that sees pop.
  initial begin
    logic p;
    rx_empty = 1'b1;
    fifo_top = 8'h00;
    forever begin
      @(negedge busclk);
      p = pop;
      @(posedge busclk);
      #1;
      if (p) begin
        pops++;
        if (up_q.size() > 0) void'(up_q.pop_front());
      end
      rx_empty = (up_q.size() == 0);
      fifo_top = (up_q.size() == 0) ? 8'h00 : up_q[0];
    end
  end

  // Scoreboard: every IRQ rising edge must deliver the oldest expected byte.
  always @(negedge busclk) begin
    if (kbd_irq && !irq_prev) begin
      irqs++;
      check1("irq_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check8("kbd_data", kbd_data, exp_q.pop_front());
    end
    irq_prev = kbd_irq;
  end

  task automatic send(input logic [7:0] b);
    up_q.push_back(b);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    @(negedge busclk);
    while (!kbd_busy && n < 60) begin
      @(negedge busclk);
      n++;
    end
    check1(tag, kbd_busy, 1'b1);
  endtask

  task automatic ack();
    @(posedge busclk);
    #1 kbd_ack = 1'b1;
    @(posedge busclk);
    #1 kbd_ack = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      wait_hold(tag);
      ack();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int irq0;
    int pops0;
    bit pop_seen;
    bit stable;

    rstn    = 1'b0;
    kbd_ack = 1'b0;
    repeat (3) @(negedge busclk);
    check1("rst_pop", pop, 1'b0);
    check8("rst_data", kbd_data, 8'h00);
    check1("rst_irq", kbd_irq, 1'b0);
    check1("rst_busy", kbd_busy, 1'b0);
    rstn = 1'b1;
    repeat (5) @(negedge busclk);

    // 1: make then break of A, with IRQ latency measurement
    send(8'h1C); expect_byte(8'h1E);
    n = 0;
    @(negedge busclk);
    while (rx_empty && n < 20) begin @(negedge busclk); n++; end
    lat = 0;
    while (lat < 20) begin
      @(negedge busclk);
      lat++;
      if (kbd_irq) break;
    end
    check32("irq_latency", lat, 3);
    wait_hold("hold_1c");
    ack();
    @(negedge busclk);
    check1("ack_irq_clr", kbd_irq, 1'b0);
    check1("ack_busy_clr", kbd_busy, 1'b0);
    check8("ack_data_kept", kbd_data, 8'h1E);
    send(8'hF0); send(8'h1C); expect_byte(8'h9E);
    wait_hold("hold_f01c");
    check8("brk_1c", kbd_data, 8'h9E);
    ack();

    // 2: extended cursor-up make/break
    irq0 = irqs;
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
`ifdef PS2_XT_EXT_PREFIX_EN
    expect_byte(8'hE0); expect_byte(8'h48);
    expect_byte(8'hE0); expect_byte(8'hC8);
    drain(4, "hold_ext");
    repeat (10) @(negedge busclk);
    check32("ext_irq_count", irqs - irq0, 4);
`else
    expect_byte(8'h48); expect_byte(8'hC8);
    drain(2, "hold_ext");
    repeat (10) @(negedge busclk);
    check32("ext_irq_count", irqs - irq0, 2);
`endif

    // 3: F7, keyboard replies and break flag clearing on a reply
    send(8'h83); expect_byte(8'h41);
    send(8'hF0); send(8'h83); expect_byte(8'hC1);
    send(8'hAA); expect_byte(8'hAA);
    send(8'hFA); expect_byte(8'hFA);
    send(8'hF0); send(8'hFA); expect_byte(8'hFA);
    send(8'h1C); expect_byte(8'h1E);
    drain(6, "hold_misc");

    // 4: backpressure while the host does not ack
    repeat (4) @(negedge busclk);
    pops0 = pops;
    send(8'h76); send(8'h5A); send(8'h12);
    expect_byte(8'h01); expect_byte(8'h1C); expect_byte(8'h2A);
    wait_hold("hold_bp");
    pop_seen = 1'b0;
    stable   = 1'b1;
    repeat (50) begin
      @(negedge busclk);
      if (pop) pop_seen = 1'b1;
      if (kbd_data !== 8'h01) stable = 1'b0;
    end
    check1("bp_pop_low", pop_seen, 1'b0);
    check1("bp_data_stable", stable, 1'b1);
    check8("bp_data", kbd_data, 8'h01);
    check1("bp_irq", kbd_irq, 1'b1);
    drain(3, "hold_bp_drain");
    repeat (6) @(negedge busclk);
    check32("bp_pop_count", pops - pops0, 3);

    // 5: reset while a break is pending
`ifdef PS2_XT_EXT_PREFIX_EN
    send(8'hF0); send(8'hE0); expect_byte(8'hE0);
    wait_hold("hold_rst");
`else
    send(8'hF0);
    repeat (10) @(negedge busclk);
`endif
    @(negedge busclk);
    rstn = 1'b0;
    #1;
    check1("rst2_irq", kbd_irq, 1'b0);
    check1("rst2_busy", kbd_busy, 1'b0);
    check8("rst2_data", kbd_data, 8'h00);
    repeat (2) @(negedge busclk);
    check1("rst2_pop", pop, 1'b0);
    rstn = 1'b1;
    repeat (5) @(negedge busclk);
    send(8'h1C); expect_byte(8'h1E);
    wait_hold("hold_post_rst");
    check8("post_rst_make", kbd_data, 8'h1E);
    ack();

    // 6: spurious ack in IDLE must not release the next byte
    repeat (3) @(negedge busclk);
    ack();
    repeat (3) @(negedge busclk);
    send(8'h1C); expect_byte(8'h1E);
    wait_hold("hold_spur");
    repeat (10) @(negedge busclk);
    check1("spur_irq_held", kbd_irq, 1'b1);
    ack();
    @(negedge busclk);
    check1("spur_irq_clr", kbd_irq, 1'b0);

    repeat (10) @(negedge busclk);
    check32("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
